// File: rtl/lane_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lane_serializer_pkg
//  Purpose  : Shared state encoding and lane-mask scan helpers for lane_serializer
//  Revision : 1.0  initial release
// ============================================================================
package lane_serializer_pkg;

    localparam int c_max_lanes = 32;
    localparam int c_idx_w     = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic               found;
        logic [c_idx_w-1:0] idx;
    } lane_pos_t;

    // Lowest set bit strictly above 'from'; pass from = -1 to find the lowest set bit.
    function automatic lane_pos_t next_set(input logic [c_max_lanes-1:0] mask, input int from);
        lane_pos_t r;
        r = '0;
        for (int i = 0; i < c_max_lanes; i++) begin
            if (!r.found && (i > from) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = c_idx_w'(i);
            end
        end
        return r;
    endfunction

    function automatic logic has_above(input logic [c_max_lanes-1:0] mask, input int from);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_max_lanes; i++) begin
            if ((i > from) && mask[i]) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_serializer_mux.sv
`default_nettype none
// ============================================================================
//  Module   : lane_serializer_mux
//  Purpose  : N-lane by M-bit word lane selector (MUX block)
//  Revision : 1.0  initial release
// ============================================================================
module lane_serializer_mux #(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int WIDTH = 3
) (
    input  logic [N*M-1:0]   i_data,
    input  logic [WIDTH-1:0] i_sel,
    output logic [M-1:0]     o_lane
);

    logic [M-1:0] w_lanes [2**WIDTH];

    // Select codes beyond the last real lane read as zero, so the index is always in range.
    generate
        for (genvar k = 0; k < 2**WIDTH; k++) begin : g_lane
            if (k < N) begin : g_used
                assign w_lanes[k] = i_data[M*(k+1)-1 -: M];
            end else begin : g_pad
                assign w_lanes[k] = '0;
            end
        end
    endgenerate

    assign o_lane = w_lanes[i_sel];

endmodule
`default_nettype wire

// File: rtl/lane_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_serializer
//  Purpose  : Holds an N-lane word and emits its enabled lanes one per cycle
//  Revision : 1.0  initial release
// ============================================================================
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*M-1:0]     pdata,
    input  logic [N-1:0]       lane_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [M-1:0]       data_o,
    output logic [WIDTH-1:0]   lane_o,
    output logic               last_o,
    output logic               busy
);

    state_t             r_state;
    logic [N*M-1:0]     r_word;
    logic [N-1:0]       r_mask;
    logic [WIDTH-1:0]   r_sel;
    logic               r_last;

    lane_pos_t          w_first;
    lane_pos_t          w_next;
    logic               w_first_last;
    logic               w_next_last;
    logic               w_accept;
    logic               w_fire;

    // last_o is precomputed alongside the select so it leaves straight from a flop.
    always_comb begin
        w_first      = next_set(32'(lane_mask), -1);
        w_first_last = !has_above(32'(lane_mask), int'(w_first.idx));
        w_next       = next_set(32'(r_mask), int'(r_sel));
        w_next_last  = !has_above(32'(r_mask), int'(w_next.idx));
    end

    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_SEND) && out_ready && r_last);
    assign w_accept = in_valid && in_ready;
    assign w_fire   = (r_state == ST_SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_mask  <= '0;
            r_sel   <= '0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_word <= pdata;
            r_mask <= lane_mask;
            if (w_first.found) begin
                r_state <= ST_SEND;
                r_sel   <= WIDTH'(w_first.idx);
                r_last  <= w_first_last;
            end else begin
                r_state <= ST_IDLE;
                r_sel   <= '0;
                r_last  <= 1'b0;
            end
        end else if (w_fire) begin
            if (r_last) begin
                r_state <= ST_IDLE;
                r_last  <= 1'b0;
            end else if (w_next.found) begin
                r_sel  <= WIDTH'(w_next.idx);
                r_last <= w_next_last;
            end
        end
    end

    lane_serializer_mux #(
        .M     (M),
        .N     (N),
        .WIDTH (WIDTH)
    ) u_mux (
        .i_data (r_word),
        .i_sel  (r_sel),
        .o_lane (data_o)
    );

    assign out_valid = (r_state == ST_SEND);
    assign busy      = (r_state == ST_SEND);
    assign lane_o    = r_sel;
    assign last_o    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_lane_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_serializer
//  Purpose  : Directed self-checking bench for lane_serializer (M=8, N=4, WIDTH=2)
//  Revision : 1.0  initial release
// ============================================================================
module tb_lane_serializer;

    localparam int c_m = 8;
    localparam int c_n = 4;
    localparam int c_w = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [c_n*c_m-1:0] pdata = '0;
    logic [c_n-1:0]     lane_mask = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [c_m-1:0]     data_o;
    logic [c_w-1:0]     lane_o;
    logic               last_o;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    lane_serializer #(
        .M     (c_m),
        .N     (c_n),
        .WIDTH (c_w)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pdata     (pdata),
        .lane_mask (lane_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .lane_o    (lane_o),
        .last_o    (last_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nth_lane(input logic [3:0] m, input int k);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (cnt == k) return i;
                cnt++;
            end
        end
        return 0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the word is taken.
    task automatic offer(input logic [31:0] d, input logic [3:0] m);
        in_valid  = 1'b1;
        pdata     = d;
        lane_mask = m;
        #1;
        for (int c = 0; c < 20 && !in_ready; c++) begin
            @(negedge clk);
            #1;
        end
        check("offer_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walks the beats of a held word, driving out_ready from rdy[cycle % 16].
    task automatic drain(input logic [31:0] d, input logic [3:0] m, input logic [15:0] rdy,
                         input int exp_beats);
        int beat;
        int el;
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < exp_beats; cyc++) begin
            out_ready = rdy[cyc % 16];
            #1;
            el = nth_lane(m, beat);
            check("beat_valid", out_valid, 1'b1);
            check("beat_busy", busy, 1'b1);
            check("beat_data", data_o, d[el*8 +: 8]);
            check("beat_lane", lane_o, el);
            check("beat_last", last_o, (beat == exp_beats - 1));
            if (beat == exp_beats - 1) check("in_ready_last", in_ready, out_ready);
            if (out_ready) beat++;
            @(negedge clk);
        end
        check("beat_count", beat, exp_beats);
        out_ready = 1'b1;
        #1;
        check("idle_after_word", out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_lane", lane_o, 0);
        check("rst_last", last_o, 1'b0);
        check("rst_data", data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full mask, no backpressure: AA/0 BB/1 CC/2 DD/3
        out_ready = 1'b1;
        offer(32'hDDCCBBAA, 4'b1111);
        drain(32'hDDCCBBAA, 4'b1111, 16'hFFFF, 4);

        // Sparse mask: 22/1 then 44/3
        @(negedge clk);
        offer(32'h44332211, 4'b1010);
        drain(32'h44332211, 4'b1010, 16'hFFFF, 2);

        // Single enabled lane is both first and last
        @(negedge clk);
        offer(32'h44332211, 4'b0100);
        drain(32'h44332211, 4'b0100, 16'hFFFF, 1);

        // Backpressure: out_ready 1,0,0,1,...
        @(negedge clk);
        offer(32'hDDCCBBAA, 4'b1111);
        drain(32'hDDCCBBAA, 4'b1111, 16'h9999, 4);

        // Back-to-back: second word held on the input throughout
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pdata     = 32'hDDCCBBAA;
        lane_mask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        pdata = 32'h88776655;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("b2b_data", data_o, 8'hAA + 8'(k * 8'h11));
            check("b2b_lane", lane_o, k);
            check("b2b_in_ready", in_ready, (k == 3));
            @(negedge clk);
        end
        #1;
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_data", data_o, 8'h55);
        check("b2b_second_lane", lane_o, 0);
        in_valid = 1'b0;
        drain(32'h88776655, 4'b1111, 16'hFFFF, 4);

        // Zero mask: accepted and dropped
        @(negedge clk);
        offer(32'h12345678, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("zero_out_valid", out_valid, 1'b0);
            check("zero_in_ready", in_ready, 1'b1);
            check("zero_busy", busy, 1'b0);
            @(negedge clk);
        end

        // Reset mid-word, after beat 1 fired
        offer(32'hDDCCBBAA, 4'b1111);
        #1;
        check("mid_first", data_o, 8'hAA);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_lane", lane_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        offer(32'h44332211, 4'b1010);
        drain(32'h44332211, 4'b1010, 16'hFFFF, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
